// File: rtl/loop_iter_gen.sv
// Nested loop index generator: NDEPTH counters (level 0 innermost) that step one beat per accepted handshake.
// Optional build macro LOOPGEN_BREAK_EN adds i_brk, which forces level 0 to its last index for that beat.

module loop_iter_level #(
   parameter int IDX_DW = 11
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clr,
   input  logic              i_load,
   input  logic              i_step,
   input  logic              i_wrap,
   input  logic [IDX_DW-1:0] i_size,
   output logic [IDX_DW-1:0] o_idx,
   output logic              o_at_last
);
   localparam logic [IDX_DW-1:0] ONE = IDX_DW'(1);

   logic [IDX_DW-1:0] size_q;
   logic [IDX_DW-1:0] last;

   // a size of 0 behaves like a size of 1
   assign last      = (size_q == '0) ? '0 : size_q - ONE;
   assign o_at_last = (o_idx == last);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         size_q <= '0;
         o_idx  <= '0;
      end else if (i_clr) begin
         o_idx  <= '0;
      end else if (i_load) begin
         size_q <= i_size;
         o_idx  <= '0;
      end else if (i_step) begin
         o_idx  <= i_wrap ? '0 : o_idx + ONE;
      end
   end
endmodule

module loop_iter_gen #(
   parameter int NDEPTH = 3,
   parameter int IDX_DW = 11
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_start,
   input  logic                          i_clr,
`ifdef LOOPGEN_BREAK_EN
   input  logic                          i_brk,
`endif
   input  logic [NDEPTH-1:0][IDX_DW-1:0] i_loopSize,
   output logic [NDEPTH-1:0][IDX_DW-1:0] o_idx,
   output logic                          o_dval,
   input  logic                          i_rdy,
   output logic [NDEPTH-1:0]             o_loopEnd,
   output logic                          o_busy,
   output logic                          o_done
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state, state_nxt;
   logic [NDEPTH-1:0] at_last;
   logic [NDEPTH-1:0] chain;
   logic [NDEPTH-1:0] step;
   logic              run, beat, load, fin, lvl0_last;

   assign run  = (state == S_RUN);
   assign beat = run & i_rdy;
   assign load = (state == S_IDLE) & i_start & ~i_clr;
   assign fin  = beat & chain[NDEPTH-1];

`ifdef LOOPGEN_BREAK_EN
   assign lvl0_last = at_last[0] | i_brk;
`else
   assign lvl0_last = at_last[0];
`endif

   assign chain[0] = lvl0_last;
   assign step[0]  = beat & ~chain[NDEPTH-1];

   // level k advances only when every inner level is wrapping this beat
   for (genvar k = 1; k < NDEPTH; k++) begin : g_chain
      assign chain[k] = chain[k-1] & at_last[k];
      assign step[k]  = beat & ~chain[NDEPTH-1] & chain[k-1];
   end

   for (genvar k = 0; k < NDEPTH; k++) begin : g_lvl
      loop_iter_level #(.IDX_DW(IDX_DW)) u_lvl (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_clr     (i_clr),
         .i_load    (load),
         .i_step    (step[k]),
         .i_wrap    (chain[k]),
         .i_size    (i_loopSize[k]),
         .o_idx     (o_idx[k]),
         .o_at_last (at_last[k])
      );
   end

   always_comb begin
      state_nxt = state;
      if (i_clr) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (i_start) state_nxt = S_RUN;
            S_RUN:   if (fin) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   assign o_dval    = run;
   assign o_busy    = (state != S_IDLE);
   assign o_done    = (state == S_DONE);
   assign o_loopEnd = run ? chain : '0;
endmodule

// File: tb/tb_loop_iter_gen.sv
// Scoreboard bench for loop_iter_gen: a linear-count model fills a queue, a negedge monitor checks every beat.
module tb_loop_iter_gen;
   localparam int ND = 3;
   localparam int DW = 11;

   logic                  i_clk = 1'b0;
   logic                  i_rst, i_start, i_clr, i_rdy;
   logic [ND-1:0][DW-1:0] i_loopSize, o_idx;
   logic                  o_dval, o_busy, o_done;
   logic [ND-1:0]         o_loopEnd;
`ifdef LOOPGEN_BREAK_EN
   logic                  i_brk = 1'b0;
`endif

   loop_iter_gen #(.NDEPTH(ND), .IDX_DW(DW)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_start    (i_start),
      .i_clr      (i_clr),
`ifdef LOOPGEN_BREAK_EN
      .i_brk      (i_brk),
`endif
      .i_loopSize (i_loopSize),
      .o_idx      (o_idx),
      .o_dval     (o_dval),
      .i_rdy      (i_rdy),
      .o_loopEnd  (o_loopEnd),
      .o_busy     (o_busy),
      .o_done     (o_done)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [ND-1:0][DW-1:0] idx;
      logic [ND-1:0]         lend;
      bit                    last;
   } beat_t;

   beat_t q[$];
   int    n_cmp = 0, n_err = 0;
   int    beats = 0, exp_total = 0, brk_at = 0;
   bit    done_due = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Beat n of an unbroken run has idx[k] = (n / prod(e[j], j<k)) % e[k]; a break jumps n to level 0's last index.
   task automatic push_run(input int s[ND], input int brk);
      int    e[ND];
      int    id[ND];
      int    n, b, dv;
      bit    all, fin;
      beat_t t;
      n = 0; b = 0; fin = 1'b0;
      for (int k = 0; k < ND; k++) e[k] = (s[k] == 0) ? 1 : s[k];
      while (!fin) begin
         b++;
         dv = 1;
         for (int k = 0; k < ND; k++) begin
            id[k] = (n / dv) % e[k];
            dv    = dv * e[k];
         end
         all = 1'b1;
         for (int k = 0; k < ND; k++) begin
            all       = all && ((k == 0 && b == brk) || id[k] == e[k] - 1);
            t.lend[k] = all;
            t.idx[k]  = DW'(id[k]);
         end
         t.last = all;
         fin    = all;
         q.push_back(t);
         if (b == brk) n = n - id[0] + e[0] - 1;
         n++;
      end
      exp_total = b;
   endtask

   // called at posedge+1 in IDLE; returns at posedge+1 of the first RUN cycle
   task automatic start_run(input int s[ND], input int brk);
      brk_at = brk;
      beats  = 0;
      push_run(s, brk);
`ifdef LOOPGEN_BREAK_EN
      i_brk = (brk_at == 1);
`endif
      for (int k = 0; k < ND; k++) i_loopSize[k] = DW'(s[k]);
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      for (int k = 0; k < ND; k++) i_loopSize[k] = DW'($urandom);
   endtask

   // mode 0: rdy held 1, mode 1: toggle, mode 2: random
   task automatic drive_run(input int mode, input int budget, output int run_cyc);
      run_cyc = 0;
      for (int c = 0; c < budget; c++) begin
         if (o_dval) run_cyc++;
         if (!o_busy && q.size() == 0 && !done_due) return;
         @(posedge i_clk); #1;
         case (mode)
            0:       i_rdy = 1'b1;
            1:       i_rdy = ~i_rdy;
            default: i_rdy = 1'($urandom_range(0, 1));
         endcase
      end
      flag("run_timeout");
   endtask

   always @(negedge i_clk) begin
      if (!i_rst) begin
         check("done_pulse", 64'(o_done), 64'(done_due));
         if (done_due) begin
            check("beats_per_run", 64'(beats), 64'(exp_total));
            done_due = 1'b0;
            beats    = 0;
         end
         if (o_dval) begin
            if (q.size() == 0) begin
               flag("dval_without_expected_beat");
            end else begin
               check("idx", 64'(o_idx), 64'(q[0].idx));
               check("loopEnd", 64'(o_loopEnd), 64'(q[0].lend));
               if (i_rdy) begin
                  beats++;
                  if (q[0].last) done_due = 1'b1;
                  void'(q.pop_front());
               end
            end
         end else if (o_loopEnd != '0) begin
            check("loopEnd_outside_run", 64'(o_loopEnd), 64'(0));
         end
`ifdef LOOPGEN_BREAK_EN
         i_brk = (brk_at != 0) && (beats + 1 == brk_at);
`endif
      end
   end

   task automatic flush();
      q.delete();
      beats    = 0;
      done_due = 1'b0;
      brk_at   = 0;
   endtask

   initial begin
      int rc;
      i_rst = 1'b1; i_start = 1'b0; i_clr = 1'b0; i_rdy = 1'b0; i_loopSize = '0;
      #3;
      check("rst_dval", 64'(o_dval), 64'(0));
      check("rst_busy", 64'(o_busy), 64'(0));
      check("rst_done", 64'(o_done), 64'(0));
      check("rst_idx", 64'(o_idx), 64'(0));
      check("rst_loopEnd", 64'(o_loopEnd), 64'(0));
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;

      // basic 3x2x2 at full rate
      start_run('{3, 2, 2}, 0);
      i_rdy = 1'b1;
      drive_run(0, 200, rc);
      check("full_rate_run_cycles", 64'(rc), 64'(12));

      // 3x2x2 with rdy toggling: 12 beats over 23 cycles
      start_run('{3, 2, 2}, 0);
      i_rdy = 1'b1;
      drive_run(1, 200, rc);
      check("toggle_run_cycles", 64'(rc), 64'(23));

      // all-zero sizes: a single beat
      start_run('{0, 0, 0}, 0);
      i_rdy = 1'b1;
      drive_run(0, 50, rc);
      check("zero_size_run_cycles", 64'(rc), 64'(1));

      // abort after beat 5, then a fresh 4x1x1 run
      start_run('{3, 2, 2}, 0);
      i_rdy = 1'b1;
      for (int c = 0; c < 100 && beats < 5; c++) begin
         @(posedge i_clk); #1;
      end
      check("beats_before_clr", 64'(beats), 64'(5));
      i_clr = 1'b1; i_rdy = 1'b0;
      @(posedge i_clk); #1;
      i_clr = 1'b0;
      flush();
      check("clr_busy", 64'(o_busy), 64'(0));
      check("clr_dval", 64'(o_dval), 64'(0));
      check("clr_idx", 64'(o_idx), 64'(0));
      repeat (3) @(posedge i_clk);
      #1;
      start_run('{4, 1, 1}, 0);
      i_rdy = 1'b1;
      drive_run(0, 100, rc);
      check("post_clr_run_cycles", 64'(rc), 64'(4));

      // clr together with start in IDLE stays IDLE
      i_clr = 1'b1; i_start = 1'b1; i_loopSize = '1;
      @(posedge i_clk); #1;
      i_clr = 1'b0; i_start = 1'b0;
      check("clr_start_busy", 64'(o_busy), 64'(0));

      // asynchronous reset mid-run
      start_run('{3, 2, 2}, 0);
      i_rdy = 1'b1;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk); #2;
      i_rst = 1'b1;
      #1;
      check("async_rst_dval", 64'(o_dval), 64'(0));
      check("async_rst_busy", 64'(o_busy), 64'(0));
      check("async_rst_loopEnd", 64'(o_loopEnd), 64'(0));
      flush();
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      check("post_rst_idle_busy", 64'(o_busy), 64'(0));

      // start pulse during RUN must be ignored
      start_run('{3, 2, 2}, 0);
      i_rdy = 1'b1;
      repeat (4) @(posedge i_clk);
      #1;
      i_start = 1'b1; i_loopSize = '0;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      drive_run(0, 200, rc);

`ifdef LOOPGEN_BREAK_EN
      start_run('{5, 2, 1}, 2);
      i_rdy = 1'b1;
      drive_run(0, 100, rc);
      check("brk_run_cycles", 64'(rc), 64'(7));
      brk_at = 0;
`endif

      // random sizes with random backpressure
      for (int r = 0; r < 20; r++) begin
         int s[ND];
         for (int k = 0; k < ND; k++) s[k] = $urandom_range(0, 4);
         start_run(s, 0);
         i_rdy = 1'($urandom_range(0, 1));
         drive_run(2, 600, rc);
      end

      repeat (2) @(posedge i_clk);
      if (q.size() != 0) check("queue_drained", 64'(q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
